// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and helpers shared by the BRAM controller and its bench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

  function automatic logic [3:0] size_to_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = 4'b0011 << {addr[1], 1'b0};
      HSIZE_WORD: m = 4'hF;
      default:    m = 4'h0;
    endcase
    return m;
  endfunction

  // Sizes above a word and addresses not aligned to the transfer size are illegal.
  function automatic logic is_legal(input logic [2:0] hsize, input logic [1:0] addr);
    logic ok;
    case (hsize)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr[0];
      HSIZE_WORD: ok = (addr == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite bus bundle between a master and the BRAM controller slave.
interface ahb_bram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait AHB-Lite slave for a split-port BRAM: byte-write port A, registered-read port B,
// with write-to-read forwarding and a two-cycle ERROR response for illegal transfers.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_ctrl_if.slave        ahb,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_bad_acc;
  logic                  w_fwd_hit;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [3:0]            w_mask;
  logic [31:0]           w_rdata_merged;
  logic                  w_hreadyout;
  logic                  w_hresp;
  logic                  w_unused;

  err_state_e            r_state;
  err_state_e            w_state_next;
  logic                  r_wr_pend;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [3:0]            r_mask;
  logic                  r_rd_pend;
  logic                  r_fwd_pend;
  logic [31:0]           r_fwd_data;
  logic [3:0]            r_fwd_mask;

  assign w_accept  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign w_legal   = is_legal(ahb.HSIZE, ahb.HADDR[1:0]);
  assign w_word    = ahb.HADDR[ADDR_WIDTH+1:2];
  assign w_mask    = size_to_mask(ahb.HSIZE, ahb.HADDR[1:0]);
  assign w_wr_acc  = w_accept & w_legal &  ahb.HWRITE;
  assign w_rd_acc  = w_accept & w_legal & ~ahb.HWRITE;
  assign w_bad_acc = w_accept & ~w_legal;

  // A read landing while a write data phase is live sees stale RAM data next cycle.
  assign w_fwd_hit = w_rd_acc & r_wr_pend & (r_waddr == w_word);

  assign w_unused = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

  always_comb begin
    w_state_next = r_state;
    w_hreadyout  = 1'b1;
    w_hresp      = RESP_OKAY;
    case (r_state)
      ST_OKAY: begin
        if (w_bad_acc) w_state_next = ST_ERR1;
      end
      ST_ERR1: begin
        w_hreadyout  = 1'b0;
        w_hresp      = RESP_ERROR;
        w_state_next = ST_ERR2;
      end
      ST_ERR2: begin
        w_hresp      = RESP_ERROR;
        w_state_next = w_bad_acc ? ST_ERR1 : ST_OKAY;
      end
      default: begin
        w_state_next = ST_OKAY;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_OKAY;
      r_wr_pend  <= 1'b0;
      r_waddr    <= '0;
      r_mask     <= 4'h0;
      r_rd_pend  <= 1'b0;
      r_fwd_pend <= 1'b0;
      r_fwd_data <= 32'h0;
      r_fwd_mask <= 4'h0;
    end else begin
      r_state    <= w_state_next;
      r_wr_pend  <= w_wr_acc;
      r_rd_pend  <= w_rd_acc;
      r_fwd_pend <= w_fwd_hit;
      if (w_wr_acc) begin
        r_waddr <= w_word;
        r_mask  <= w_mask;
      end
      if (w_fwd_hit) begin
        r_fwd_data <= ahb.HWDATA;
        r_fwd_mask <= r_mask;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign w_rdata_merged[gi*8 +: 8] = (r_fwd_pend & r_fwd_mask[gi]) ?
                                         r_fwd_data[gi*8 +: 8] : BRAM_RDATA[gi*8 +: 8];
    end
  endgenerate

  assign BRAM_ADDRA = r_waddr;
  assign BRAM_WDATA = ahb.HWDATA;
  assign BRAM_WE    = r_wr_pend ? r_mask : 4'h0;
  assign BRAM_ADDRB = w_word;

  assign ahb.HREADYOUT = w_hreadyout;
  assign ahb.HRESP     = w_hresp;
  // Zero outside read data phases so the bus never carries X after reset.
  assign ahb.HRDATA    = r_rd_pend ? w_rdata_merged : 32'h0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Randomized bench for ahb_bram_ctrl against a byte-level memory model.
module tb_ahb_bram_ctrl;
  import ahb_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int NW    = 16;

  logic          HCLK;
  logic          HRESETn;
  logic [AW-1:0] BRAM_ADDRA;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WE;
  logic [AW-1:0] BRAM_ADDRB;
  logic [31:0]   BRAM_RDATA;

  ahb_bram_ctrl_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .ahb        (bus.slave),
    .BRAM_ADDRA (BRAM_ADDRA),
    .BRAM_WDATA (BRAM_WDATA),
    .BRAM_WE    (BRAM_WE),
    .BRAM_ADDRB (BRAM_ADDRB),
    .BRAM_RDATA (BRAM_RDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Block RAM: byte-write port A, registered read port B (old data on collision).
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge HCLK) begin
    BRAM_RDATA <= mem[BRAM_ADDRB];
    for (int b = 0; b < 4; b++)
      if (BRAM_WE[b]) mem[BRAM_ADDRA][b*8 +: 8] <= BRAM_WDATA[b*8 +: 8];
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [0:NW-1];

  int          t_kind  [0:31];   // 0 idle/busy, 1 deselected, 2 transfer
  bit          t_write [0:31];
  int          t_size  [0:31];
  logic [31:0] t_addr  [0:31];
  logic [31:0] t_wdata [0:31];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [3:0] exp_mask(input int size, input logic [31:0] a);
    int nb;
    int m;
    nb = 1 << size;
    m  = ((1 << nb) - 1) << (a % 4);
    return 4'(m);
  endfunction

  task automatic set_t(input int i, input int kind, input bit wr, input int size,
                       input logic [31:0] addr, input logic [31:0] wd);
    t_kind[i]  = kind;
    t_write[i] = wr;
    t_size[i]  = size;
    t_addr[i]  = addr;
    t_wdata[i] = wd;
  endtask

  task automatic rand_entry(input int i, input int maxw, input int xfer_pct);
    int r;
    int w;
    int s;
    int lane;
    r = $urandom_range(0, 99);
    s = $urandom_range(0, 2);
    w = $urandom_range(0, maxw);
    lane = (s == 0) ? $urandom_range(0, 3) : (s == 1) ? 2 * $urandom_range(0, 1) : 0;
    set_t(i, (r < xfer_pct) ? 2 : (r % 2), bit'($urandom_range(0, 1)), s,
          ($urandom & 32'hFFFF_C000) | 32'(w << 2) | 32'(lane), $urandom);
  endtask

  task automatic drive_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HADDR  = $urandom;
    bus.HSIZE  = 3'(HSIZE_WORD);
    bus.HWRITE = 1'b0;
  endtask

  // Runs table entries 0..n-1 back to back; each data phase checked in the following cycle.
  task automatic run_burst(input int n, input string tag);
    int idx;
    logic [31:0] exp;
    logic [3:0]  m;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.HSEL   = (t_kind[i] != 1);
        bus.HTRANS = (t_kind[i] == 2) ? HTRANS_NONSEQ :
                     (t_kind[i] == 1) ? HTRANS_NONSEQ : 2'($urandom_range(0, 1));
        bus.HADDR  = t_addr[i];
        bus.HSIZE  = 3'(t_size[i]);
        bus.HWRITE = t_write[i];
      end else begin
        drive_idle();
      end
      bus.HWDATA = (i > 0 && t_write[i-1]) ? t_wdata[i-1] : $urandom;
      @(negedge HCLK);
      if (i > 0) begin
        idx = widx(t_addr[i-1]);
        n_vec++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== RESP_OKAY) begin
          n_err++;
          $display("FAIL %s[%0d] resp: got ready=%b resp=%b want ready=1 resp=0",
                   tag, i-1, bus.HREADYOUT, bus.HRESP);
        end
        if (t_kind[i-1] == 2 && t_write[i-1]) begin
          m = exp_mask(t_size[i-1], t_addr[i-1]);
          n_vec++;
          if (BRAM_WE !== m || BRAM_ADDRA !== AW'(idx)) begin
            n_err++;
            $display("FAIL %s[%0d] write: got we=%b addra=%h want we=%b addra=%h",
                     tag, i-1, BRAM_WE, BRAM_ADDRA, m, AW'(idx));
          end
          for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[idx][b*8 +: 8] = t_wdata[i-1][b*8 +: 8];
        end else begin
          n_vec++;
          if (BRAM_WE !== 4'h0) begin
            n_err++;
            $display("FAIL %s[%0d] no_write: got we=%b want we=0000", tag, i-1, BRAM_WE);
          end
          if (t_kind[i-1] == 2) begin
            exp = ref_mem[idx];
            n_vec++;
            if (bus.HRDATA !== exp) begin
              n_err++;
              $display("FAIL %s[%0d] read %h: got %h want %h",
                       tag, i-1, t_addr[i-1], bus.HRDATA, exp);
            end
          end
        end
      end
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive_idle();
    bus.HWDATA = 32'h0;
    repeat (2) @(negedge HCLK);
    n_vec++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== RESP_OKAY || BRAM_WE !== 4'h0 ||
        BRAM_ADDRA !== '0 || $isunknown(bus.HRDATA)) begin
      n_err++;
      $display("FAIL reset: got ready=%b resp=%b we=%b addra=%h rdata=%h want 1 0 0000 000 known",
               bus.HREADYOUT, bus.HRESP, BRAM_WE, BRAM_ADDRA, bus.HRDATA);
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_init();
    for (int w = 0; w < NW; w++)
      set_t(w, 2, 1'b1, 2, ($urandom & 32'hFFFF_C000) | 32'(w << 2), $urandom);
    run_burst(NW, "init");
  endtask

  task automatic test_directed();
    set_t(0, 2, 1'b1, 2, 32'h0000_0010, 32'hDEAD_BEEF);
    set_t(1, 0, 1'b0, 2, 32'h0000_0010, 32'h0);
    set_t(2, 2, 1'b0, 2, 32'h0000_0010, 32'h0);
    run_burst(3, "word_rw");
    set_t(0, 2, 1'b1, 2, 32'h0000_0010, 32'h1122_3344);
    set_t(1, 2, 1'b1, 0, 32'h0000_0013, 32'hAA00_0000);
    set_t(2, 0, 1'b0, 2, 32'h0000_0010, 32'h0);
    set_t(3, 2, 1'b0, 2, 32'h0000_0010, 32'h0);
    run_burst(4, "byte_wr");
    set_t(0, 2, 1'b1, 1, 32'h0000_0012, 32'h5566_0000);
    set_t(1, 2, 1'b0, 2, 32'h0000_0010, 32'h0);
    run_burst(2, "half_fwd");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 24; i++) rand_entry(i, 3, 100);
      run_burst(24, "b2b");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 24; i++) rand_entry(i, NW - 1, 70);
      run_burst(24, "rand");
    end
  endtask

  // Illegal transfer, then a legal word read of raddr issued in the second ERROR cycle.
  task automatic test_error(input logic [31:0] baddr, input int bsize, input bit bwr,
                            input logic [31:0] raddr, input string tag);
    logic [31:0] exp;
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = baddr;
    bus.HSIZE  = 3'(bsize);
    bus.HWRITE = bwr;
    bus.HWDATA = $urandom;
    @(posedge HCLK);
    #1;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = $urandom;
    @(negedge HCLK);
    n_vec++;
    if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== RESP_ERROR || BRAM_WE !== 4'h0) begin
      n_err++;
      $display("FAIL %s err1: got ready=%b resp=%b we=%b want ready=0 resp=1 we=0000",
               tag, bus.HREADYOUT, bus.HRESP, BRAM_WE);
    end
    @(posedge HCLK);
    #1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = raddr;
    bus.HSIZE  = 3'(HSIZE_WORD);
    bus.HWRITE = 1'b0;
    @(negedge HCLK);
    n_vec++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== RESP_ERROR || BRAM_WE !== 4'h0) begin
      n_err++;
      $display("FAIL %s err2: got ready=%b resp=%b we=%b want ready=1 resp=1 we=0000",
               tag, bus.HREADYOUT, bus.HRESP, BRAM_WE);
    end
    @(posedge HCLK);
    #1;
    drive_idle();
    @(negedge HCLK);
    exp = ref_mem[widx(raddr)];
    n_vec++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== RESP_OKAY || bus.HRDATA !== exp) begin
      n_err++;
      $display("FAIL %s read_after: got ready=%b resp=%b data=%h want ready=1 resp=0 data=%h",
               tag, bus.HREADYOUT, bus.HRESP, bus.HRDATA, exp);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset_mid_write();
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = 32'h0000_0020;
    bus.HSIZE  = 3'(HSIZE_WORD);
    bus.HWRITE = 1'b1;
    @(posedge HCLK);
    #1;
    drive_idle();
    bus.HWDATA = 32'hCAFE_F00D;
    #1;
    n_vec++;
    if (BRAM_WE !== 4'hF) begin
      n_err++;
      $display("FAIL rst_mid pre: got we=%b want we=1111", BRAM_WE);
    end
    HRESETn = 1'b0;
    #1;
    n_vec++;
    if (BRAM_WE !== 4'h0 || bus.HREADYOUT !== 1'b1 || bus.HRESP !== RESP_OKAY) begin
      n_err++;
      $display("FAIL rst_mid: got we=%b ready=%b resp=%b want we=0000 ready=1 resp=0",
               BRAM_WE, bus.HREADYOUT, bus.HRESP);
    end
    @(posedge HCLK);
    #1;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    set_t(0, 2, 1'b0, 2, 32'h0000_0020, 32'h0);
    run_burst(1, "rst_mid_read");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_back_to_back();
    test_error(32'h0000_0002, 2, 1'b1, 32'h0000_0000, "misaligned_wr");
    test_error(32'h0000_0014, 3, 1'b0, 32'h0000_0014, "size3_rd");
    test_error(32'h0000_0011, 1, 1'b1, 32'h0000_0010, "misaligned_half");
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
